fifo_sync_ctrl: RTL and testbench

- Synchronous FIFO controller that drives the team's two-port BRAM (bram_2psync).
- The BRAM writes on its port B. Its port A read address is registered, and read data is valid one cycle after the address is presented.
- Provides valid/ready streaming on both sides with first-word-fall-through output.
- A 2-entry output skid stage hides the RAM read latency, so the FIFO sustains one word per cycle.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_out_skid.sv | 64 ++++++
 rtl/fifo_sync_ctrl.sv | 120 ++++++++++++
 tb/tb_fifo_sync_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and constants for the synchronous FIFO controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

  // Output skid stage depth; two entries cover the one-cycle RAM read latency.
  localparam int SKID_DEPTH = 2;

  // Read/write pointer width: RAM address plus one wrap bit.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  // Occupancy counter width: holds up to 2**addr_w + SKID_DEPTH words.
  function automatic int cnt_w(input int addr_w);
    return addr_w + 2;
  endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// fifo_out_skid: 2-entry output buffer fed by RAM read data, head presented first-word-fall-through.
// Latency: a captured word is visible at head_dat the cycle after capture.
// Backpressure: none internally; the fetch logic never issues a capture that would overflow.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   cap_vld, cap_dat     capture strobe and data (RAM read data this cycle)
//   pop                  head consumed this cycle (only asserted while head_vld)
//   head_dat, head_vld   oldest buffered word and its valid
//   stage_cnt            number of buffered words (0..2)
module fifo_out_skid
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_vld,
  input  logic [DATA_W-1:0] cap_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] head_dat,
  output logic              head_vld,
  output logic [1:0]        stage_cnt
);

  localparam logic [1:0] FULL_CNT = 2'(SKID_DEPTH);

  logic [DATA_W-1:0] ent0;   // head
  logic [DATA_W-1:0] ent1;   // second-oldest

  assign head_dat = ent0;
  assign head_vld = (stage_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ent0      <= '0;
      ent1      <= '0;
      stage_cnt <= 2'd0;
    end else begin
      case ({cap_vld, pop})
        2'b11: begin
          // Pop and capture together: count unchanged, new word goes behind the survivor.
          if (stage_cnt == FULL_CNT) begin
            ent0 <= ent1;
            ent1 <= cap_dat;
          end else begin
            ent0 <= cap_dat;
          end
        end
        2'b10: begin
          if (stage_cnt == 2'd0) ent0 <= cap_dat;
          else                   ent1 <= cap_dat;
          stage_cnt <= stage_cnt + 2'd1;
        end
        2'b01: begin
          ent0      <= ent1;
          stage_cnt <= stage_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: synchronous FIFO controller around a two-port BRAM (write port B, registered-read port A).
// Latency: a word pushed into an empty FIFO appears at out_data two cycles later; 1 word/cycle sustained.
// Backpressure: in_ready drops only when the RAM is full; out side is valid/ready with FWFT head.
//
// Optional: define FIFO_CTRL_ERR_EN to add sticky ovf_err / udf_err protocol-error outputs.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   in_data/in_valid/in_ready         write stream
//   out_data/out_valid/out_ready      read stream (first-word-fall-through)
//   count                             words held: RAM + in-flight fetch + output stage
//   ram_we/ram_waddr/ram_wdata        BRAM port B write
//   ram_raddr/ram_rdata               BRAM port A read (data valid one cycle after address)
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 6,
  localparam int CNT_W  = cnt_w(ADDR_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef FIFO_CTRL_ERR_EN
  ,
  output logic              ovf_err,
  output logic              udf_err
`endif
);

  localparam int               PTR_W     = ptr_w(ADDR_W);
  localparam logic [PTR_W-1:0] RAM_DEPTH = PTR_W'(2 ** ADDR_W);
  localparam logic [2:0]       SKID_LIM  = 3'(SKID_DEPTH);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] ram_cnt;
  logic             ram_full;
  logic             ram_empty;
  logic             pend;        // a RAM read was issued last cycle; ram_rdata is valid now
  logic [1:0]       stage_cnt;
  logic [2:0]       in_pipe;
  logic             push;
  logic             pop;
  logic             fetch;

  // Pointer difference wraps naturally thanks to the extra MSB.
  assign ram_cnt   = wptr - rptr;
  assign ram_full  = (ram_cnt == RAM_DEPTH);
  assign ram_empty = (ram_cnt == '0);

  assign in_ready = !ram_full;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Words already committed to the output side (buffered or arriving next edge).
  // "stage_cnt + pend - pop < SKID_DEPTH" is rearranged to stay unsigned.
  assign in_pipe = {1'b0, stage_cnt} + {2'b00, pend};
  assign fetch   = !ram_empty && (in_pipe < (SKID_LIM + {2'b00, pop}));

  assign ram_we    = push && !reset;
  assign ram_waddr = wptr[ADDR_W-1:0];
  assign ram_wdata = in_data;
  assign ram_raddr = rptr[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      pend  <= 1'b0;
      count <= '0;
    end else begin
      if (push)  wptr <= wptr + PTR_W'(1);
      if (fetch) rptr <= rptr + PTR_W'(1);
      pend <= fetch;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // pend is cleared by reset, so read data in flight across a reset is never captured.
  fifo_out_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .cap_vld   (pend),
    .cap_dat   (ram_rdata),
    .pop       (pop),
    .head_dat  (out_data),
    .head_vld  (out_valid),
    .stage_cnt (stage_cnt)
  );

`ifdef FIFO_CTRL_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (in_valid && !in_ready)   ovf_err <= 1'b1;
      if (out_ready && !out_valid) udf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb_fifo_sync_ctrl: self-checking bench for fifo_sync_ctrl (ADDR_W=2) with a registered-read BRAM model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_fifo_sync_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int CW = AW + 2;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
`ifdef FIFO_CTRL_ERR_EN
  logic          ovf_err;
  logic          udf_err;
`endif

  fifo_sync_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata)
`ifdef FIFO_CTRL_ERR_EN
    ,
    .ovf_err   (ovf_err),
    .udf_err   (udf_err)
`endif
  );

  // Two-port BRAM: synchronous write, registered read address.
  logic [DW-1:0] mem [4];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_ov"},  32'(out_valid), 32'd0);
    chk({tag, "_cnt"}, 32'(count),     32'd0);
    chk({tag, "_rdy"}, 32'(in_ready),  32'd1);
    chk({tag, "_od"},  32'(out_data),  32'd0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          e_rdy;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic [CW-1:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } ent_t;

  vec_t vt [14];
  ent_t q [$];
  int   edge_n;
  int   pushed;
  logic push, pop, exp_ov;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill to full with the consumer stalled, then stream with both sides active.
    // Expected values are the state after the edge that consumes the row's inputs.
    vt[0]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 4'd1};
    vt[1]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 4'd2};
    vt[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 4'd3};
    vt[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 4'd4};
    vt[4]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h01, 4'd5};
    vt[5]  = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 8'h01, 4'd6};
    vt[6]  = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 8'h01, 4'd6};  // 0x07 dropped
    vt[7]  = '{1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 8'h02, 4'd5};  // 0x08 dropped, first pop
    vt[8]  = '{1'b1, 8'h09, 1'b1, 1'b1, 1'b1, 8'h03, 4'd5};
    vt[9]  = '{1'b1, 8'h0A, 1'b1, 1'b1, 1'b1, 8'h04, 4'd5};
    vt[10] = '{1'b1, 8'h0B, 1'b1, 1'b1, 1'b1, 8'h05, 4'd5};
    vt[11] = '{1'b1, 8'h0C, 1'b1, 1'b1, 1'b1, 8'h06, 4'd5};
    vt[12] = '{1'b1, 8'h0D, 1'b1, 1'b1, 1'b1, 8'h09, 4'd5};
    vt[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0A, 4'd4};

    do_reset("rst0");

    // Single word latency into an empty FIFO.
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    @(negedge clk);
    chk("lat_e0_ov", 32'(out_valid), 32'd0);
    chk("lat_e0_cnt", 32'(count), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_e1_ov", 32'(out_valid), 32'd0);
    chk("lat_e1_cnt", 32'(count), 32'd1);
    @(negedge clk);
    chk("lat_e2_ov", 32'(out_valid), 32'd1);
    chk("lat_e2_od", 32'(out_data), 32'hA5);
    chk("lat_e2_cnt", 32'(count), 32'd1);
    @(negedge clk);
    chk("lat_e3_ov", 32'(out_valid), 32'd0);
    chk("lat_e3_cnt", 32'(count), 32'd0);

    // Table: fill, overflow drop, then full-rate streaming.
    do_reset("rst1");
    for (int i = 0; i < 14; i++) begin
      in_valid = vt[i].iv; in_data = vt[i].id; out_ready = vt[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_rdy", i), 32'(in_ready),  32'(vt[i].e_rdy));
      chk($sformatf("vec%0d_ov", i),  32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("vec%0d_od", i),  32'(out_data),  32'(vt[i].e_od));
      chk($sformatf("vec%0d_cnt", i), 32'(count),     32'(vt[i].e_cnt));
    end

    // Reset while a fetch is in flight with three words held.
    do_reset("rst2");
    in_valid = 1'b1;
    in_data = 8'h11; @(negedge clk);
    in_data = 8'h22; @(negedge clk);
    in_data = 8'h33; @(negedge clk);
    chk("mid_cnt_pre", 32'(count), 32'd3);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_ov", 32'(out_valid), 32'd0);
    chk("mid_cnt", 32'(count), 32'd0);
    chk("mid_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("mid_ov_after", 32'(out_valid), 32'd0);
    chk("mid_cnt_after", 32'(count), 32'd0);
    chk("mid_od_after", 32'(out_data), 32'd0);

    // Randomized streaming against a queue model.
    do_reset("rst3");
    edge_n = 0;
    pushed = 0;
    q.delete();
    for (int cyc = 0; cyc < 6000 && !(pushed == 256 && q.size() == 0); cyc++) begin
      exp_ov = (q.size() > 0) && ((edge_n - q[0].t) >= 2);
      chk("rnd_ov", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) chk("rnd_od", 32'(out_data), 32'(q[0].d));
      chk("rnd_cnt", 32'(count), 32'(q.size()));
      if (q.size() < 4)  chk("rnd_rdy_hi", 32'(in_ready), 32'd1);
      if (q.size() >= 6) chk("rnd_rdy_lo", 32'(in_ready), 32'd0);
      in_valid  = (pushed < 256) && ($urandom_range(0, 1) == 1);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      push = in_valid && in_ready;
      pop  = out_valid && out_ready;
      @(posedge clk);
      edge_n++;
      if (pop && q.size() > 0) void'(q.pop_front());
      if (push) begin
        q.push_back('{in_data, edge_n});
        pushed++;
      end
      @(negedge clk);
    end
    chk("rnd_all_pushed", 32'(pushed), 32'd256);
    chk("rnd_drained", 32'(q.size()), 32'd0);
    chk("rnd_cnt_end", 32'(count), 32'd0);

`ifdef FIFO_CTRL_ERR_EN
    do_reset("rst4");
    chk("err_ovf_rst", 32'(ovf_err), 32'd0);
    chk("err_udf_rst", 32'(udf_err), 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = 8'(i + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("err_ovf_set", 32'(ovf_err), 32'd1);
    chk("err_udf_clr", 32'(udf_err), 32'd0);
    repeat (2) @(negedge clk);
    chk("err_ovf_sticky", 32'(ovf_err), 32'd1);
    do_reset("rst5");
    chk("err_ovf_clr", 32'(ovf_err), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("err_udf_set", 32'(udf_err), 32'd1);
    chk("err_ovf_still0", 32'(ovf_err), 32'd0);
    do_reset("rst6");
    chk("err_udf_clr2", 32'(udf_err), 32'd0);
    chk("err_ovf_clr2", 32'(ovf_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
